// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared types and helpers for the UART program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Bit period in clocks, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_8n1.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_8n1
// Description : 8N1 UART receiver with 2-flop input synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_8n1
    import prog_loader_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err_pulse,
    output logic       busy
);

    localparam int DIV   = baud_div(CLK_HZ, BAUD);
    localparam int CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] c_DIV  = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] c_HALF = CNT_W'(DIV / 2);

    if (DIV < 4) begin : g_div_check
        $error("uart_rx_8n1: bit period must be at least 4 clocks");
    end

    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_q;
    rx_state_t        r_state;
    rx_state_t        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             w_fall;
    logic             w_tick;

    assign w_fall = r_rx_q & ~r_sync2;
    // Counter expires on its last count, so a load of N samples N clocks later.
    assign w_tick = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rx_q  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_rx_q  <= r_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_fall) w_next = START;
            START: if (w_tick) w_next = r_sync2 ? IDLE : DATA;
            DATA:  if (w_tick && (r_bit == 3'd7)) w_next = STOP;
            STOP:  if (w_tick) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy            = (r_state != IDLE);
        byte_valid      = (r_state == STOP) && w_tick && r_sync2;
        frame_err_pulse = (r_state == STOP) && w_tick && !r_sync2;
        byte_data       = r_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fall) r_cnt <= c_HALF;
                end
                START: begin
                    if (w_tick) begin
                        r_cnt <= c_DIV;
                        r_bit <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        r_cnt   <= c_DIV;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                STOP: begin
                    if (!w_tick) r_cnt <= r_cnt - CNT_W'(1);
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_prog_loader
// Description : Loads UART bytes as little-endian words into RAM port B, or
//               passes the CPU bus write path through when not loading.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    input  logic              prog_en,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       data_in,
    input  logic              we_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [31:0]       data_out,
    output logic              we_out,
    output logic [ADDR_W:0]   word_count,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [ADDR_W:0] c_COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic              w_byte_valid;
    logic [7:0]        w_byte_data;
    logic              w_frame_err_pulse;
    logic              w_prog_rise;
    logic              r_prog_q;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_idx;
    logic [31:0]       r_word;
    logic              r_we;
    logic [ADDR_W:0]   r_count;
    logic              r_ferr;

    uart_rx_8n1 #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk             (clk),
        .rst             (rst),
        .rx              (uart_rx),
        .byte_valid      (w_byte_valid),
        .byte_data       (w_byte_data),
        .frame_err_pulse (w_frame_err_pulse),
        .busy            (busy)
    );

    assign w_prog_rise = prog_en & ~r_prog_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prog_q <= 1'b0;
            r_addr   <= '0;
            r_idx    <= '0;
            r_word   <= '0;
            r_we     <= 1'b0;
            r_count  <= '0;
            r_ferr   <= 1'b0;
        end else begin
            r_prog_q <= prog_en;
            r_we     <= 1'b0;
            if (w_prog_rise) begin
                r_addr  <= '0;
                r_idx   <= '0;
                r_count <= '0;
                r_ferr  <= 1'b0;
            end else begin
                if (w_frame_err_pulse) r_ferr <= 1'b1;
                // Outside loader mode bytes are dropped; a pending write is lost.
                if (!prog_en) begin
                    r_idx <= '0;
                end else if (r_we) begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_idx  <= '0;
                    if (r_count != c_COUNT_MAX) r_count <= r_count + (ADDR_W+1)'(1);
                end else if (w_byte_valid) begin
                    r_word[{r_idx, 3'b000} +: 8] <= w_byte_data;
                    if (r_idx == 2'd3) r_we <= 1'b1;
                    else               r_idx <= r_idx + 2'd1;
                end
            end
        end
    end

    assign addr_out   = prog_en ? r_addr : addr_in;
    assign data_out   = prog_en ? r_word : data_in;
    assign we_out     = prog_en ? r_we   : we_in;
    assign word_count = r_count;
    assign frame_err  = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_prog_loader
// Description : Directed, table-driven bench for uart_prog_loader (DIV = 10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_prog_loader;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int ADDR_W = 12;
    localparam int DIV    = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              uart_rx;
    logic              prog_en;
    logic [ADDR_W-1:0] addr_in;
    logic [31:0]       data_in;
    logic              we_in;
    logic [ADDR_W-1:0] addr_out;
    logic [31:0]       data_out;
    logic              we_out;
    logic [ADDR_W:0]   word_count;
    logic              frame_err;
    logic              busy;

    uart_prog_loader #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .prog_en    (prog_en),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .we_in      (we_in),
        .addr_out   (addr_out),
        .data_out   (data_out),
        .we_out     (we_out),
        .word_count (word_count),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:3][7:0]   b;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [ADDR_W:0]   cnt;
    } word_vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic              we;
        logic [ADDR_W-1:0] exp_addr;
        logic [31:0]       exp_data;
        logic              exp_we;
    } pt_vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    int  we_run = 0, max_we_run = 0;
    int  stray_we = 0;
    bit  busy_seen = 0;
    bit  gap_en = 0, gap_seen = 0;
    int  gap_run = 0, max_gap = 0;

    // Observers sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst && prog_en && we_out) begin
            wr_addr_q.push_back(addr_out);
            wr_data_q.push_back(data_out);
            we_run++;
            if (we_run > max_we_run) max_we_run = we_run;
        end else begin
            we_run = 0;
        end
        if (!prog_en && !we_in && we_out) stray_we++;
        if (busy) busy_seen = 1;
        if (gap_en) begin
            if (busy) begin
                if (gap_seen && gap_run > max_gap) max_gap = gap_run;
                gap_seen = 1;
                gap_run  = 0;
            end else begin
                gap_run++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_write(input string name, input logic [ADDR_W-1:0] ea, input logic [31:0] ed);
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        a = (wr_addr_q.size() > 0) ? wr_addr_q[0] : 'x;
        d = (wr_data_q.size() > 0) ? wr_data_q[0] : 'x;
        check({name, "_addr"}, 64'(a), 64'(ea));
        check({name, "_data"}, 64'(d), 64'(ed));
        if (wr_addr_q.size() > 0) begin
            wr_addr_q.pop_front();
            wr_data_q.pop_front();
        end
    endtask

    task automatic drive(input logic v);
        @(posedge clk);
        #1 uart_rx = v;
        repeat (DIV - 1) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive(1'b0);
        for (int i = 0; i < 8; i++) drive(b[i]);
        drive(stop);
        if (!stop) drive(1'b1);
    endtask

    task automatic toggle_prog();
        @(posedge clk); #1 prog_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 prog_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    word_vec_t wv[3];
    pt_vec_t   pv[3];

    initial begin
        wv[0] = '{b: '{8'h78, 8'h56, 8'h34, 8'h12}, addr: 12'h000, data: 32'h1234_5678, cnt: 13'd1};
        wv[1] = '{b: '{8'hEF, 8'hBE, 8'hAD, 8'hDE}, addr: 12'h001, data: 32'hDEAD_BEEF, cnt: 13'd2};
        wv[2] = '{b: '{8'h00, 8'hFF, 8'h00, 8'hFF}, addr: 12'h002, data: 32'hFF00_FF00, cnt: 13'd3};
        pv[0] = '{addr: 12'h3F0, data: 32'hDEAD_BEEF, we: 1'b1, exp_addr: 12'h3F0, exp_data: 32'hDEAD_BEEF, exp_we: 1'b1};
        pv[1] = '{addr: 12'h001, data: 32'h0000_0000, we: 1'b0, exp_addr: 12'h001, exp_data: 32'h0000_0000, exp_we: 1'b0};
        pv[2] = '{addr: 12'hFFF, data: 32'hA5A5_5A5A, we: 1'b1, exp_addr: 12'hFFF, exp_data: 32'hA5A5_5A5A, exp_we: 1'b1};

        rst = 1'b1; uart_rx = 1'b1; prog_en = 1'b0;
        addr_in = '0; data_in = '0; we_in = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        @(posedge clk); #1 rst = 1'b0; prog_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_we_out", 64'(we_out), 64'd0);
        check("rst_addr_out", 64'(addr_out), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);

        // Word packing from the vector table
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) send_byte(wv[i].b[k], 1'b1);
            repeat (20) @(negedge clk);
            check($sformatf("word%0d_nwrites", i), 64'(wr_addr_q.size()), 64'd1);
            check_write($sformatf("word%0d", i), wv[i].addr, wv[i].data);
            check($sformatf("word%0d_count", i), 64'(word_count), 64'(wv[i].cnt));
        end

        toggle_prog();
        check("rise_clears_count", 64'(word_count), 64'd0);

        // Back-to-back frames, no idle gap on the line
        max_gap = 0; gap_run = 0; gap_seen = 0; gap_en = 1;
        for (int k = 1; k <= 8; k++) send_byte(8'(k), 1'b1);
        repeat (20) @(negedge clk);
        gap_en = 0;
        check("b2b_nwrites", 64'(wr_addr_q.size()), 64'd2);
        check_write("b2b_w0", 12'h000, 32'h0403_0201);
        check_write("b2b_w1", 12'h001, 32'h0807_0605);
        check("b2b_count", 64'(word_count), 64'd2);
        // Stop is sampled mid-bit, so the idle gap is the remaining half bit.
        check($sformatf("b2b_busy_gap_%0d", max_gap), 64'(max_gap >= 1 && max_gap <= DIV / 2 + 1), 64'd1);

        // Short low glitch: false start rejected
        busy_seen = 0;
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_started", 64'(busy_seen), 64'd1);
        check("glitch_busy", 64'(busy), 64'd0);
        check("glitch_frame_err", 64'(frame_err), 64'd0);
        check("glitch_nwrites", 64'(wr_addr_q.size()), 64'd0);

        // Bad stop bit
        send_byte(8'hAA, 1'b0);
        repeat (5) @(negedge clk);
        check("ferr_set", 64'(frame_err), 64'd1);
        check("ferr_nwrites", 64'(wr_addr_q.size()), 64'd0);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        repeat (20) @(negedge clk);
        check_write("ferr_next_word", 12'h002, 32'h4433_2211);
        check("ferr_sticky", 64'(frame_err), 64'd1);
        toggle_prog();
        check("ferr_cleared", 64'(frame_err), 64'd0);

        // Pass-through
        @(posedge clk); #1 prog_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr_in = pv[i].addr; data_in = pv[i].data; we_in = pv[i].we;
            #1;
            check($sformatf("pt%0d_addr", i), 64'(addr_out), 64'(pv[i].exp_addr));
            check($sformatf("pt%0d_data", i), 64'(data_out), 64'(pv[i].exp_data));
            check($sformatf("pt%0d_we", i), 64'(we_out), 64'(pv[i].exp_we));
        end
        we_in = 1'b0;
        stray_we = 0;
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        repeat (20) @(negedge clk);
        check("pt_no_loader_we", 64'(stray_we), 64'd0);
        check("pt_count_held", 64'(word_count), 64'd0);

        // Reset in the middle of byte 2
        @(posedge clk); #1 prog_en = 1'b1; addr_in = '0; data_in = '0;
        repeat (3) @(posedge clk);
        send_byte(8'hA1, 1'b1); send_byte(8'hB2, 1'b1);
        drive(1'b0); drive(1'b1); drive(1'b0); drive(1'b1);
        @(posedge clk); #1 rst = 1'b1; uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_we_out", 64'(we_out), 64'd0);
        check("mrst_frame_err", 64'(frame_err), 64'd0);
        check("mrst_count", 64'(word_count), 64'd0);
        check("mrst_addr_out", 64'(addr_out), 64'd0);
        check("mrst_data_out", 64'(data_out), 64'd0);
        wr_addr_q.delete(); wr_data_q.delete();
        send_byte(8'hC1, 1'b1); send_byte(8'hC2, 1'b1);
        send_byte(8'hC3, 1'b1); send_byte(8'hC4, 1'b1);
        repeat (20) @(negedge clk);
        check("mrst_nwrites", 64'(wr_addr_q.size()), 64'd1);
        check_write("mrst_word", 12'h000, 32'hC4C3_C2C1);
        check("mrst_count_after", 64'(word_count), 64'd1);

        check("we_pulse_width", 64'(max_we_run), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
